// File: rtl/mem_load_return_pkg.sv
// +----------------------------------------------------------------------+
// | mem_load_return_pkg: load request metadata shared with issue stage    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_load_return_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_width_e;

  localparam int unsigned LOAD_TAG_W = 5;

  typedef struct packed {
    mem_width_e width;
    logic       is_unsigned;
    logic [1:0] byte_idx;
  } load_meta_t;

  typedef struct packed {
    load_meta_t            meta;
    logic [LOAD_TAG_W-1:0] tag;
  } load_req_t;

endpackage

`default_nettype wire

// File: rtl/mem_load_return_load_align_ext.sv
// +----------------------------------------------------------------------+
// | load_align_ext: selects byte/half/word from a load word and extends   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module load_align_ext
  import mem_load_return_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  mem_width_e  width_i,
  input  logic        unsigned_i,
  input  logic [1:0]  byte_idx_i,
  output logic [31:0] data_o,
  output logic        bad_width_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte      = rdata_i[{byte_idx_i, 3'b000} +: 8];
    // Only aligned halves are ever issued, so idx[0] never matters here.
    w_half      = rdata_i[{byte_idx_i[1], 4'b0000} +: 16];
    data_o      = '0;
    bad_width_o = 1'b0;
    case (width_i)
      BYTE:    data_o = {{24{!unsigned_i && w_byte[7]}}, w_byte};
      HALF:    data_o = {{16{!unsigned_i && w_half[15]}}, w_half};
      WORD:    data_o = rdata_i;
      default: bad_width_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_load_return.sv
// +----------------------------------------------------------------------+
// | mem_load_return: tracks issued loads and returns aligned results      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_load_return
  import mem_load_return_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_width_i,
  input  logic             req_unsigned_i,
  input  logic [1:0]       req_byte_idx_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             mem_rvalid_i,
  output logic             mem_rready_o,
  input  logic [31:0]      mem_rdata_i,
  input  logic             mem_err_i,
  output logic             load_valid_o,
  input  logic             load_ready_i,
  output logic [31:0]      load_data_o,
  output logic [TAG_W-1:0] load_tag_o,
  output logic             load_fault_o,
  output logic             spurious_o,
  output logic             busy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  load_meta_t       meta_q [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic             kill_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d, fault_q, fault_d, spurious_q, spurious_d;
  logic [31:0]      data_q, data_d;
  logic [TAG_W-1:0] otag_q, otag_d;

  logic       push, pop, accept, empty, load_new;
  load_meta_t head_meta, push_meta;
  logic [31:0] align_data;
  logic        align_bad;

  assign push_meta = '{width: mem_width_e'(req_width_i),
                       is_unsigned: req_unsigned_i,
                       byte_idx: req_byte_idx_i};
  assign head_meta = meta_q[rd_ptr_q];

  load_align_ext u_align (
    .rdata_i     (mem_rdata_i),
    .width_i     (head_meta.width),
    .unsigned_i  (head_meta.is_unsigned),
    .byte_idx_i  (head_meta.byte_idx),
    .data_o      (align_data),
    .bad_width_o (align_bad)
  );

  always_comb begin
    empty       = (count_q == '0);
    req_ready_o = (count_q != FULL_CNT);
    mem_rready_o = !valid_q || load_ready_i;
    accept      = mem_rvalid_i && mem_rready_o;
    push        = req_valid_i && req_ready_o;
    pop         = accept && !empty;
    // Flush in the pop cycle does not affect the head's already-latched kill bit.
    load_new    = pop && !kill_q[rd_ptr_q];
    spurious_d  = accept && empty;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);

    valid_d = valid_q;
    data_d  = data_q;
    otag_d  = otag_q;
    fault_d = fault_q;
    if (load_new) begin
      valid_d = 1'b1;
      fault_d = mem_err_i || align_bad;
      data_d  = (mem_err_i || align_bad) ? 32'd0 : align_data;
      otag_d  = tag_q[rd_ptr_q];
    end else if (flush_i || load_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      otag_q     <= '0;
      fault_q    <= 1'b0;
      spurious_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        meta_q[i] <= '0;
        tag_q[i]  <= '0;
        kill_q[i] <= 1'b0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      otag_q     <= otag_d;
      fault_q    <= fault_d;
      spurious_q <= spurious_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_i) kill_q[i] <= 1'b1;
      end
      if (push) begin
        meta_q[wr_ptr_q] <= push_meta;
        tag_q[wr_ptr_q]  <= req_tag_i;
        kill_q[wr_ptr_q] <= 1'b0;
      end
    end
  end

  assign load_valid_o = valid_q;
  assign load_data_o  = data_q;
  assign load_tag_o   = otag_q;
  assign load_fault_o = fault_q;
  assign spurious_o   = spurious_q;
  assign busy_o       = (count_q != '0) || valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_load_return.sv
// +----------------------------------------------------------------------+
// | tb_mem_load_return: directed self-checking bench for mem_load_return  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_load_return;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_width = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [1:0]  req_idx = 2'd0;
  logic [4:0]  req_tag = 5'd0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_err = 1'b0;
  logic        load_ready = 1'b1;

  logic        req_ready, mem_rready, load_valid, load_fault, spurious, busy;
  logic [31:0] load_data;
  logic [4:0]  load_tag;

  logic        d4_req_ready, d4_mem_rready, d4_load_valid, d4_load_fault, d4_spurious, d4_busy;
  logic [31:0] d4_load_data;
  logic [4:0]  d4_load_tag;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_load_return #(.DEPTH(2), .TAG_W(5)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_width_i(req_width),
    .req_unsigned_i(req_unsigned), .req_byte_idx_i(req_idx), .req_tag_i(req_tag),
    .mem_rvalid_i(mem_rvalid), .mem_rready_o(mem_rready), .mem_rdata_i(mem_rdata),
    .mem_err_i(mem_err), .load_valid_o(load_valid), .load_ready_i(load_ready),
    .load_data_o(load_data), .load_tag_o(load_tag), .load_fault_o(load_fault),
    .spurious_o(spurious), .busy_o(busy)
  );

  // Deeper instance on the same stimulus, used where three reads must be tracked.
  mem_load_return #(.DEPTH(4), .TAG_W(5)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(d4_req_ready), .req_width_i(req_width),
    .req_unsigned_i(req_unsigned), .req_byte_idx_i(req_idx), .req_tag_i(req_tag),
    .mem_rvalid_i(mem_rvalid), .mem_rready_o(d4_mem_rready), .mem_rdata_i(mem_rdata),
    .mem_err_i(mem_err), .load_valid_o(d4_load_valid), .load_ready_i(load_ready),
    .load_data_o(d4_load_data), .load_tag_o(d4_load_tag), .load_fault_o(d4_load_fault),
    .spurious_o(d4_spurious), .busy_o(d4_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [1:0] w, input logic u,
                         input logic [1:0] idx, input logic [4:0] tag);
    req_valid    = v;
    req_width    = w;
    req_unsigned = u;
    req_idx      = idx;
    req_tag      = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests_run++; if (load_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", load_valid); end
    tests_run++; if (load_data !== 32'd0) begin fails++; $display("FAIL reset_data got %h exp 0", load_data); end
    tests_run++; if (load_tag !== 5'd0) begin fails++; $display("FAIL reset_tag got %h exp 0", load_tag); end
    tests_run++; if (load_fault !== 1'b0 || spurious !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_flags got fault=%b spur=%b busy=%b exp 0/0/0", load_fault, spurious, busy); end
    tests_run++; if (req_ready !== 1'b1 || mem_rready !== 1'b1) begin fails++; $display("FAIL reset_ready got req=%b mem=%b exp 1/1", req_ready, mem_rready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_byte_signed();
    set_req(1'b1, 2'd0, 1'b0, 2'd2, 5'd3);
    tick();
    set_req(1'b0, 2'd0, 1'b0, 2'd0, 5'd0);
    tests_run++; if (busy !== 1'b1 || load_valid !== 1'b0) begin fails++; $display("FAIL byte_busy got busy=%b valid=%b exp 1/0", busy, load_valid); end
    mem_rvalid = 1'b1; mem_rdata = 32'h1280_3456;
    tick();
    mem_rvalid = 1'b0;
    tests_run++; if (load_valid !== 1'b1) begin fails++; $display("FAIL byte_valid got %b exp 1", load_valid); end
    tests_run++; if (load_data !== 32'hFFFF_FF80) begin fails++; $display("FAIL byte_data got %h exp ffffff80", load_data); end
    tests_run++; if (load_tag !== 5'd3 || load_fault !== 1'b0) begin fails++; $display("FAIL byte_tag got tag=%0d fault=%b exp 3/0", load_tag, load_fault); end
    tick();
    tests_run++; if (load_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL byte_drain got valid=%b busy=%b exp 0/0", load_valid, busy); end
  endtask

  task automatic test_back_to_back();
    set_req(1'b1, 2'd1, 1'b1, 2'd2, 5'd7);
    tick();
    set_req(1'b1, 2'd2, 1'b0, 2'd0, 5'd9);
    tick();
    set_req(1'b0, 2'd0, 1'b0, 2'd0, 5'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_0000;
    tick();
    tests_run++; if (load_valid !== 1'b1 || load_data !== 32'h0000_BEEF || load_tag !== 5'd7) begin fails++; $display("FAIL b2b_first got v=%b d=%h t=%0d exp 1/0000beef/7", load_valid, load_data, load_tag); end
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    tests_run++; if (load_valid !== 1'b1 || load_data !== 32'hCAFE_F00D || load_tag !== 5'd9) begin fails++; $display("FAIL b2b_second got v=%b d=%h t=%0d exp 1/cafef00d/9", load_valid, load_data, load_tag); end
    tick();
    tests_run++; if (load_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL b2b_idle got valid=%b busy=%b exp 0/0", load_valid, busy); end
  endtask

  task automatic test_full_backpressure();
    set_req(1'b1, 2'd0, 1'b1, 2'd0, 5'd1);
    tick();
    set_req(1'b1, 2'd2, 1'b0, 2'd0, 5'd2);
    tick();
    set_req(1'b0, 2'd0, 1'b0, 2'd0, 5'd0);
    tests_run++; if (req_ready !== 1'b0) begin fails++; $display("FAIL full_req_ready got %b exp 0", req_ready); end
    load_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_00AB;
    tick();
    tests_run++; if (load_valid !== 1'b1 || load_data !== 32'h0000_00AB || load_tag !== 5'd1) begin fails++; $display("FAIL full_first got v=%b d=%h t=%0d exp 1/000000ab/1", load_valid, load_data, load_tag); end
    mem_rdata = 32'h1122_3344;
    #1;
    tests_run++; if (mem_rready !== 1'b0) begin fails++; $display("FAIL stall_rready got %b exp 0", mem_rready); end
    tick(); tick();
    tests_run++; if (load_valid !== 1'b1 || load_data !== 32'h0000_00AB || load_tag !== 5'd1) begin fails++; $display("FAIL stall_hold got v=%b d=%h t=%0d exp 1/000000ab/1", load_valid, load_data, load_tag); end
    tests_run++; if (req_ready !== 1'b1) begin fails++; $display("FAIL stall_req_ready got %b exp 1", req_ready); end
    load_ready = 1'b1;
    #1;
    tests_run++; if (mem_rready !== 1'b1) begin fails++; $display("FAIL release_rready got %b exp 1", mem_rready); end
    tick();
    mem_rvalid = 1'b0;
    tests_run++; if (load_valid !== 1'b1 || load_data !== 32'h1122_3344 || load_tag !== 5'd2) begin fails++; $display("FAIL full_second got v=%b d=%h t=%0d exp 1/11223344/2", load_valid, load_data, load_tag); end
    tick();
    tests_run++; if (load_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL full_idle got valid=%b busy=%b exp 0/0", load_valid, busy); end
  endtask

  task automatic test_flush();
    set_req(1'b1, 2'd2, 1'b0, 2'd0, 5'd4);
    tick();
    set_req(1'b1, 2'd2, 1'b0, 2'd0, 5'd5);
    tick();
    set_req(1'b1, 2'd2, 1'b0, 2'd0, 5'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_req(1'b0, 2'd0, 1'b0, 2'd0, 5'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0044;
    tick();
    tests_run++; if (d4_load_valid !== 1'b0) begin fails++; $display("FAIL flush_kill1 got %b exp 0", d4_load_valid); end
    mem_rdata = 32'h0000_0055;
    tick();
    tests_run++; if (d4_load_valid !== 1'b0) begin fails++; $display("FAIL flush_kill2 got %b exp 0", d4_load_valid); end
    mem_rdata = 32'h0000_0066;
    tick();
    mem_rvalid = 1'b0;
    tests_run++; if (d4_load_valid !== 1'b1 || d4_load_data !== 32'h0000_0066 || d4_load_tag !== 5'd6) begin fails++; $display("FAIL flush_survivor got v=%b d=%h t=%0d exp 1/00000066/6", d4_load_valid, d4_load_data, d4_load_tag); end
    tick();
    tests_run++; if (d4_busy !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL flush_idle got busy4=%b busy=%b exp 0/0", d4_busy, busy); end
    // A stalled valid result is dropped by flush.
    set_req(1'b1, 2'd2, 1'b0, 2'd0, 5'd8);
    tick();
    set_req(1'b0, 2'd0, 1'b0, 2'd0, 5'd0);
    load_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0088;
    tick();
    mem_rvalid = 1'b0;
    tests_run++; if (load_valid !== 1'b1 || load_data !== 32'h0000_0088) begin fails++; $display("FAIL flush_out_pre got v=%b d=%h exp 1/00000088", load_valid, load_data); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    load_ready = 1'b1;
    tests_run++; if (load_valid !== 1'b0) begin fails++; $display("FAIL flush_out_clear got %b exp 0", load_valid); end
  endtask

  task automatic test_spurious_fault();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    tests_run++; if (spurious !== 1'b1 || load_valid !== 1'b0) begin fails++; $display("FAIL spur_pulse got spur=%b valid=%b exp 1/0", spurious, load_valid); end
    tick();
    tests_run++; if (spurious !== 1'b0) begin fails++; $display("FAIL spur_clear got %b exp 0", spurious); end
    set_req(1'b1, 2'd2, 1'b0, 2'd0, 5'd10);
    tick();
    set_req(1'b0, 2'd0, 1'b0, 2'd0, 5'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF; mem_err = 1'b1;
    tick();
    mem_rvalid = 1'b0; mem_err = 1'b0;
    tests_run++; if (load_valid !== 1'b1 || load_fault !== 1'b1 || load_data !== 32'd0 || load_tag !== 5'd10) begin fails++; $display("FAIL err_fault got v=%b f=%b d=%h t=%0d exp 1/1/0/10", load_valid, load_fault, load_data, load_tag); end
    set_req(1'b1, 2'd3, 1'b0, 2'd0, 5'd12);
    tick();
    set_req(1'b0, 2'd0, 1'b0, 2'd0, 5'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    tests_run++; if (load_valid !== 1'b1 || load_fault !== 1'b1 || load_data !== 32'd0 || load_tag !== 5'd12) begin fails++; $display("FAIL badwidth got v=%b f=%b d=%h t=%0d exp 1/1/0/12", load_valid, load_fault, load_data, load_tag); end
    tick();
  endtask

  task automatic test_async_reset();
    set_req(1'b1, 2'd2, 1'b0, 2'd0, 5'd11);
    tick();
    set_req(1'b1, 2'd2, 1'b0, 2'd0, 5'd13);
    tick();
    set_req(1'b0, 2'd0, 1'b0, 2'd0, 5'd0);
    load_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0011;
    tick();
    tests_run++; if (load_valid !== 1'b1 || load_tag !== 5'd11) begin fails++; $display("FAIL prereset_valid got v=%b t=%0d exp 1/11", load_valid, load_tag); end
    #2;
    rst = 1'b1;
    #1;
    tests_run++; if (load_valid !== 1'b0 || load_data !== 32'd0 || load_tag !== 5'd0 || load_fault !== 1'b0) begin fails++; $display("FAIL async_out got v=%b d=%h t=%0d f=%b exp 0/0/0/0", load_valid, load_data, load_tag, load_fault); end
    tests_run++; if (busy !== 1'b0 || spurious !== 1'b0 || req_ready !== 1'b1 || mem_rready !== 1'b1) begin fails++; $display("FAIL async_flags got busy=%b spur=%b req=%b mem=%b exp 0/0/1/1", busy, spurious, req_ready, mem_rready); end
    load_ready = 1'b1;
    tick();
    rst = 1'b0;
    mem_rdata = 32'h0000_0013;
    tick();
    mem_rvalid = 1'b0;
    tests_run++; if (spurious !== 1'b1 || load_valid !== 1'b0) begin fails++; $display("FAIL postreset_spur got spur=%b valid=%b exp 1/0", spurious, load_valid); end
    tick();
  endtask

  initial begin
    test_reset();
    test_byte_signed();
    test_back_to_back();
    test_full_backpressure();
    test_flush();
    test_spurious_fault();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

`default_nettype wire
